uart_rx_cfg: RTL and testbench
==============================

// Module: uart_rx_cfg
// PURPOSE
//  Parametrised UART receiver: 5-9 data bits, optional even/odd parity, 1 or 2 stop bits.
//  Mid-bit sampling, start-bit glitch rejection, parity/framing/break error reporting.
//  Sits between the board RX pin and the host-side loader/console logic.
//  Drop-in successor to the fixed 8N1 receiver, with the same DV/byte output semantics.
// PARAMETERS
//  CLKS_PER_BIT  87  clocks per bit = f_clk / baud; legal range 4..65535
//  DATA_BITS     8   data bits per frame, 5..9, sent LSB first
//  PARITY_MODE   0   0 = none, 1 = even, 2 = odd; 3 is illegal (fatal in simulation)
//  STOP_BITS     1   1 or 2
// PORTS
//  i_Clock       in   1          single system clock, rising edge
//  i_Reset       in   1          synchronous, active-high reset
//  i_Rx_Serial   in   1          asynchronous serial line, idles high
//  o_Rx_DV       out  1          one-cycle pulse: frame complete; byte and flags valid
//  o_Rx_Byte     out  DATA_BITS  last received data word, held until next o_Rx_DV
//  o_Parity_Err  out  1          parity mismatch on last frame; held with o_Rx_Byte
//  o_Frame_Err   out  1          any stop bit sampled low on last frame; held
//  o_Break       out  1          last frame: all data bits, parity and stop sampled 0; held
//  o_Busy        out  1          high in every state except IDLE
// BEHAVIOUR
//  Reset: state IDLE, counters 0, sync flops 1; all outputs 0.
//  Reset mid-frame aborts the frame silently; no DV is generated.
//  Sync: 2-flop synchroniser on i_Rx_Serial; the FSM sees only the synchronised value.
//  Notation: C = CLKS_PER_BIT, H = (C-1)/2 (integer divide).
//  Notation: F = DATA_BITS + (PARITY_MODE != 0) + STOP_BITS.
//  Counter width is $clog2(C). The bit counter wraps to 0 after each sample.
//  FSM states: IDLE, START, DATA, PARITY, STOP, CLEANUP, WAIT_HIGH.
//   IDLE: synchronised line = 0 -> START, with count = 0.
//   START: at count == H, re-check the line. Low -> DATA (count = 0). High -> IDLE (glitch).
//   DATA: sample at count == C-1, LSB first. After DATA_BITS samples -> PARITY if enabled, else STOP.
//   PARITY: one sample. Even: error if XOR(data, p) != 0. Odd: error if XOR(data, p) != 1.
//   STOP: STOP_BITS samples. Any sample of 0 sets frame_err.
//     After the last sample: o_Rx_DV = 1 and outputs update on the same edge -> CLEANUP.
//   CLEANUP: o_Rx_DV = 0. Line high -> IDLE; line low -> WAIT_HIGH.
//   WAIT_HIGH: remain until the line is high -> IDLE. This prevents a break from retriggering.
//  Timing: edge 0 = first edge on which i_Rx_Serial is sampled 0.
//   Start check occurs at edge 3+H.
//   Data bit k is sampled at edge 3+H+(k+1)*C.
//   o_Rx_DV is high for exactly the cycle following edge 3+H+F*C.
//  o_Parity_Err is 0 when PARITY_MODE = 0.
//  o_Break implies o_Frame_Err.
//  Back-to-back frames: a start bit immediately after the stop bit is accepted (C >= 4 guarantees it).
//  Error flags and o_Rx_Byte update only together with o_Rx_DV; they never change otherwise.
// STRUCTURE
//  uart_defs.vh (shared across UART blocks): state encodings; PARITY_NONE/EVEN/ODD constants.
//  Sub-module uart_rx_sync: parametrised 2-flop synchroniser with reset value 1.
//   The same sub-module is reused by future UART blocks.
//  The FSM, bit timer, bit index and shift register are all in uart_rx_cfg.
// TESTING
//  1. C=16, 8N1, send 0xA5 -> DV exactly 1 cycle at edge 154; byte=0xA5; all error flags 0.
//  2. C=16, 7E1, send 0x41 with parity 0 -> byte 0x41, Parity_Err=0.
//     Same frame with parity bit 1 -> Parity_Err=1.
//  3. 8N2, second stop bit driven 0 -> Frame_Err=1, Break=0, byte still captured.
//  4. Line held low for 3 frame times -> one DV with byte=0, Frame_Err=1, Break=1.
//     No further DV until the line returns high and a new start bit arrives.
//  5. Low glitch of H-1 cycles on the idle line -> FSM returns to IDLE; no DV; Busy drops.
//  6. Reset pulse mid-DATA, then a clean 0x3C frame -> no DV for the aborted frame; next DV gives 0x3C.
//     Also: two frames back-to-back with zero idle gap -> two DVs, both bytes correct.

Source files
------------

// File: rtl/uart_rx_cfg_pkg.sv
// Shared definitions for the configurable UART receiver: FSM state encoding,
// parity mode constants and the parity check helper.
package uart_rx_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_CLEANUP   = 3'd5,
    ST_WAIT_HIGH = 3'd6
  } rx_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // acc is the XOR of all received data bits, p the received parity bit.
  function automatic logic parity_bad(input int mode, input logic acc, input logic p);
    logic x;
    x = acc ^ p;
    if (mode == PARITY_EVEN) return x;
    if (mode == PARITY_ODD)  return ~x;
    return 1'b0;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous single-bit input, with a
// configurable reset value so an idle-high line reads as idle out of reset.
module uart_rx_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver (5-9 data bits, none/even/odd parity, 1-2 stop bits)
// with mid-bit sampling, start glitch rejection and parity/framing/break flags.
//
// state      | meaning
// IDLE       | line idle, waiting for a low level
// START      | half-bit wait, then re-check the start bit (glitch filter)
// DATA       | sampling data bits LSB first, one per bit period
// PARITY     | sampling the parity bit
// STOP       | sampling stop bits; DV issued on the last one
// CLEANUP    | one cycle after DV
// WAIT_HIGH  | line still low after the frame (break); wait for idle
module uart_rx_cfg
  import uart_rx_cfg_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  input  logic                 i_Rx_Serial,
  output logic                 o_Rx_DV,
  output logic [DATA_BITS-1:0] o_Rx_Byte,
  output logic                 o_Parity_Err,
  output logic                 o_Frame_Err,
  output logic                 o_Break,
  output logic                 o_Busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = 4;
  localparam logic [CW-1:0] HALF      = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] LAST      = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] DATA_LAST = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);

  if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_parity
    $fatal(1, "uart_rx_cfg: PARITY_MODE must be 0, 1 or 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2 ||
      CLKS_PER_BIT < 4 || CLKS_PER_BIT > 65535) begin : g_bad_param
    $fatal(1, "uart_rx_cfg: parameter out of range");
  end

  rx_state_t            state, state_nxt;
  logic                 rx;
  logic                 bit_tick;
  logic [CW-1:0]        count;
  logic [IW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic                 par_acc;
  logic                 par_err;
  logic                 frame_err;
  logic                 all_zero;

  uart_rx_sync #(.RESET_VAL(1'b1)) u_sync (
    .clk (i_Clock),
    .rst (i_Reset),
    .d   (i_Rx_Serial),
    .q   (rx)
  );

  assign bit_tick = (count == LAST);
  assign o_Busy   = (state != ST_IDLE);

  always_ff @(posedge i_Clock) begin
    if (i_Reset) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:      if (!rx) state_nxt = ST_START;
      ST_START:     if (count == HALF) state_nxt = rx ? ST_IDLE : ST_DATA;
      ST_DATA:
        if (bit_tick && bit_idx == DATA_LAST)
          state_nxt = (PARITY_MODE != PARITY_NONE) ? ST_PARITY : ST_STOP;
      ST_PARITY:    if (bit_tick) state_nxt = ST_STOP;
      ST_STOP:      if (bit_tick && bit_idx == STOP_LAST) state_nxt = ST_CLEANUP;
      ST_CLEANUP:   state_nxt = rx ? ST_IDLE : ST_WAIT_HIGH;
      ST_WAIT_HIGH: if (rx) state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      count        <= '0;
      bit_idx      <= '0;
      shift        <= '0;
      par_acc      <= 1'b0;
      par_err      <= 1'b0;
      frame_err    <= 1'b0;
      all_zero     <= 1'b0;
      o_Rx_DV      <= 1'b0;
      o_Rx_Byte    <= '0;
      o_Parity_Err <= 1'b0;
      o_Frame_Err  <= 1'b0;
      o_Break      <= 1'b0;
    end else begin
      o_Rx_DV <= 1'b0;
      case (state)
        ST_IDLE: begin
          count     <= '0;
          bit_idx   <= '0;
          par_acc   <= 1'b0;
          par_err   <= 1'b0;
          frame_err <= 1'b0;
          all_zero  <= 1'b1;
        end
        ST_START: count <= (count == HALF) ? '0 : count + 1'b1;
        ST_DATA: begin
          if (bit_tick) begin
            count    <= '0;
            shift    <= {rx, shift[DATA_BITS-1:1]};
            par_acc  <= par_acc ^ rx;
            all_zero <= all_zero & ~rx;
            bit_idx  <= (bit_idx == DATA_LAST) ? '0 : bit_idx + 1'b1;
          end else begin
            count <= count + 1'b1;
          end
        end
        ST_PARITY: begin
          if (bit_tick) begin
            count    <= '0;
            par_err  <= parity_bad(PARITY_MODE, par_acc, rx);
            all_zero <= all_zero & ~rx;
          end else begin
            count <= count + 1'b1;
          end
        end
        ST_STOP: begin
          if (bit_tick) begin
            count <= '0;
            // The last stop sample is folded straight into the outputs.
            if (bit_idx == STOP_LAST) begin
              bit_idx      <= '0;
              o_Rx_DV      <= 1'b1;
              o_Rx_Byte    <= shift;
              o_Parity_Err <= par_err;
              o_Frame_Err  <= frame_err | ~rx;
              o_Break      <= all_zero & ~rx;
            end else begin
              bit_idx   <= bit_idx + 1'b1;
              frame_err <= frame_err | ~rx;
              all_zero  <= all_zero & ~rx;
            end
          end else begin
            count <= count + 1'b1;
          end
        end
        default: count <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: three instances (8N1, 7E1, 8N2) at 16 clocks
// per bit, each scenario a task with inline checks against hand-computed values.
module tb_uart_rx_cfg;

  localparam int C = 16;
  localparam int H = (C - 1) / 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic rx_a, rx_b, rx_c;
  logic dv_a, dv_b, dv_c;
  logic pe_a, pe_b, pe_c;
  logic fe_a, fe_b, fe_c;
  logic brk_a, brk_b, brk_c;
  logic busy_a, busy_b, busy_c;
  logic [7:0] byte_a, byte_c;
  logic [6:0] byte_b;

  uart_rx_cfg #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u_8n1 (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx_a), .o_Rx_DV(dv_a), .o_Rx_Byte(byte_a),
    .o_Parity_Err(pe_a), .o_Frame_Err(fe_a), .o_Break(brk_a), .o_Busy(busy_a));

  uart_rx_cfg #(.CLKS_PER_BIT(C), .DATA_BITS(7), .PARITY_MODE(1), .STOP_BITS(1)) u_7e1 (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx_b), .o_Rx_DV(dv_b), .o_Rx_Byte(byte_b),
    .o_Parity_Err(pe_b), .o_Frame_Err(fe_b), .o_Break(brk_b), .o_Busy(busy_b));

  uart_rx_cfg #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(2)) u_8n2 (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx_c), .o_Rx_DV(dv_c), .o_Rx_Byte(byte_c),
    .o_Parity_Err(pe_c), .o_Frame_Err(fe_c), .o_Break(brk_c), .o_Busy(busy_c));

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int edge0  = 0;
  int dv_cnt[3];
  int dv_cyc[3];
  logic [7:0] last_a, prev_a;

  always @(posedge clk) cyc++;

  // DV pulses are counted on the falling edge so a 2-cycle pulse counts twice.
  always @(negedge clk) begin
    if (dv_a) begin dv_cnt[0]++; dv_cyc[0] = cyc; prev_a = last_a; last_a = byte_a; end
    if (dv_b) begin dv_cnt[1]++; dv_cyc[1] = cyc; end
    if (dv_c) begin dv_cnt[2]++; dv_cyc[2] = cyc; end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_rx(input int line, input logic v);
    case (line)
      0: rx_a = v;
      1: rx_b = v;
      default: rx_c = v;
    endcase
  endtask

  // bits[0] is the start bit; each bit is held for C clocks.
  task automatic drive_frame(input int line, input logic [15:0] bits, input int nbits);
    logic [15:0] b;
    b = bits;
    for (int i = 0; i < nbits; i++) begin
      set_rx(line, b[i]);
      if (i == 0) edge0 = cyc + 1;
      idle(C);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_a = 1'b1; rx_b = 1'b1; rx_c = 1'b1;
    idle(3);
    total++; if ({dv_a, pe_a, fe_a, brk_a, busy_a} !== 5'b0) $display("FAIL reset_flags_a got %b want 00000", {dv_a, pe_a, fe_a, brk_a, busy_a}); else passed++;
    total++; if ({dv_b, pe_b, fe_b, brk_b, busy_b} !== 5'b0) $display("FAIL reset_flags_b got %b want 00000", {dv_b, pe_b, fe_b, brk_b, busy_b}); else passed++;
    total++; if ({dv_c, pe_c, fe_c, brk_c, busy_c} !== 5'b0) $display("FAIL reset_flags_c got %b want 00000", {dv_c, pe_c, fe_c, brk_c, busy_c}); else passed++;
    total++; if ({byte_a, byte_b, byte_c} !== 23'h0) $display("FAIL reset_bytes got %h want 0", {byte_a, byte_b, byte_c}); else passed++;
    rst = 1'b0;
    idle(4);
  endtask

  task automatic test_8n1();
    int n0;
    n0 = dv_cnt[0];
    drive_frame(0, {1'b1, 8'hA5, 1'b0}, 10);
    idle(4);
    total++; if (dv_cnt[0] !== n0 + 1) $display("FAIL 8n1_dv_count got %0d want %0d", dv_cnt[0], n0 + 1); else passed++;
    total++; if (dv_cyc[0] - edge0 !== 154) $display("FAIL 8n1_dv_edge got %0d want 154", dv_cyc[0] - edge0); else passed++;
    total++; if (byte_a !== 8'hA5) $display("FAIL 8n1_byte got %h want a5", byte_a); else passed++;
    total++; if ({pe_a, fe_a, brk_a, busy_a} !== 4'b0) $display("FAIL 8n1_flags got %b want 0000", {pe_a, fe_a, brk_a, busy_a}); else passed++;
  endtask

  task automatic test_parity();
    int n0;
    n0 = dv_cnt[1];
    drive_frame(1, {1'b1, 1'b0, 7'h41, 1'b0}, 10);
    idle(4);
    total++; if (dv_cnt[1] !== n0 + 1) $display("FAIL 7e1_dv_count got %0d want %0d", dv_cnt[1], n0 + 1); else passed++;
    total++; if (dv_cyc[1] - edge0 !== 154) $display("FAIL 7e1_dv_edge got %0d want 154", dv_cyc[1] - edge0); else passed++;
    total++; if (byte_b !== 7'h41) $display("FAIL 7e1_byte_good got %h want 41", byte_b); else passed++;
    total++; if ({pe_b, fe_b} !== 2'b00) $display("FAIL 7e1_good_par got %b want 00", {pe_b, fe_b}); else passed++;
    drive_frame(1, {1'b1, 1'b1, 7'h41, 1'b0}, 10);
    idle(4);
    total++; if (dv_cnt[1] !== n0 + 2) $display("FAIL 7e1_dv_count2 got %0d want %0d", dv_cnt[1], n0 + 2); else passed++;
    total++; if (byte_b !== 7'h41) $display("FAIL 7e1_byte_bad got %h want 41", byte_b); else passed++;
    total++; if ({pe_b, fe_b, brk_b} !== 3'b100) $display("FAIL 7e1_bad_par got %b want 100", {pe_b, fe_b, brk_b}); else passed++;
  endtask

  task automatic test_frame_err();
    int n0;
    n0 = dv_cnt[2];
    drive_frame(2, {2'b11, 8'hC3, 1'b0}, 11);
    idle(4);
    total++; if (dv_cnt[2] !== n0 + 1) $display("FAIL 8n2_dv_count got %0d want %0d", dv_cnt[2], n0 + 1); else passed++;
    total++; if (dv_cyc[2] - edge0 !== 170) $display("FAIL 8n2_dv_edge got %0d want 170", dv_cyc[2] - edge0); else passed++;
    total++; if ({byte_c, fe_c, brk_c} !== {8'hC3, 2'b00}) $display("FAIL 8n2_clean got %h want 30c", {byte_c, fe_c, brk_c}); else passed++;
    drive_frame(2, {2'b01, 8'h5A, 1'b0}, 11);
    set_rx(2, 1'b1);
    idle(8);
    total++; if (dv_cnt[2] !== n0 + 2) $display("FAIL 8n2_err_dv_count got %0d want %0d", dv_cnt[2], n0 + 2); else passed++;
    total++; if (byte_c !== 8'h5A) $display("FAIL 8n2_err_byte got %h want 5a", byte_c); else passed++;
    total++; if ({pe_c, fe_c, brk_c, busy_c} !== 4'b0100) $display("FAIL 8n2_err_flags got %b want 0100", {pe_c, fe_c, brk_c, busy_c}); else passed++;
  endtask

  task automatic test_break();
    int n0;
    n0 = dv_cnt[0];
    set_rx(0, 1'b0);
    idle(3 * 10 * C);
    total++; if (dv_cnt[0] !== n0 + 1) $display("FAIL break_dv_count got %0d want %0d", dv_cnt[0], n0 + 1); else passed++;
    total++; if ({byte_a, fe_a, brk_a, busy_a} !== {8'h00, 3'b111}) $display("FAIL break_out got %h want 007", {byte_a, fe_a, brk_a, busy_a}); else passed++;
    set_rx(0, 1'b1);
    idle(20);
    total++; if (dv_cnt[0] !== n0 + 1) $display("FAIL break_no_retrigger got %0d want %0d", dv_cnt[0], n0 + 1); else passed++;
    total++; if (busy_a !== 1'b0) $display("FAIL break_busy_drop got %b want 0", busy_a); else passed++;
    drive_frame(0, {1'b1, 8'h81, 1'b0}, 10);
    idle(4);
    total++; if (dv_cnt[0] !== n0 + 2) $display("FAIL break_recover_count got %0d want %0d", dv_cnt[0], n0 + 2); else passed++;
    total++; if ({byte_a, fe_a, brk_a} !== {8'h81, 2'b00}) $display("FAIL break_recover_out got %h want 204", {byte_a, fe_a, brk_a}); else passed++;
  endtask

  task automatic test_glitch();
    int n0;
    n0 = dv_cnt[0];
    set_rx(0, 1'b0);
    idle(4);
    total++; if (busy_a !== 1'b1) $display("FAIL glitch_busy_rise got %b want 1", busy_a); else passed++;
    idle(H - 1 - 4);
    set_rx(0, 1'b1);
    idle(20);
    total++; if (busy_a !== 1'b0) $display("FAIL glitch_busy_drop got %b want 0", busy_a); else passed++;
    total++; if (dv_cnt[0] !== n0) $display("FAIL glitch_no_dv got %0d want %0d", dv_cnt[0], n0); else passed++;
    total++; if ({byte_a, fe_a, brk_a} !== {8'h81, 2'b00}) $display("FAIL glitch_held got %h want 204", {byte_a, fe_a, brk_a}); else passed++;
  endtask

  task automatic test_reset_mid();
    int n0;
    n0 = dv_cnt[0];
    set_rx(0, 1'b0);
    idle(C);
    set_rx(0, 1'b1);
    idle(2 * C);
    total++; if (busy_a !== 1'b1) $display("FAIL midrst_busy_pre got %b want 1", busy_a); else passed++;
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    total++; if ({byte_a, busy_a, fe_a} !== 10'h0) $display("FAIL midrst_cleared got %h want 0", {byte_a, busy_a, fe_a}); else passed++;
    idle(8 * C);
    total++; if (dv_cnt[0] !== n0) $display("FAIL midrst_no_dv got %0d want %0d", dv_cnt[0], n0); else passed++;
    drive_frame(0, {1'b1, 8'h3C, 1'b0}, 10);
    idle(4);
    total++; if (dv_cnt[0] !== n0 + 1) $display("FAIL midrst_next_count got %0d want %0d", dv_cnt[0], n0 + 1); else passed++;
    total++; if (byte_a !== 8'h3C) $display("FAIL midrst_next_byte got %h want 3c", byte_a); else passed++;
  endtask

  task automatic test_back_to_back();
    int n0;
    n0 = dv_cnt[0];
    drive_frame(0, {1'b1, 8'h12, 1'b0}, 10);
    drive_frame(0, {1'b1, 8'h34, 1'b0}, 10);
    idle(8);
    total++; if (dv_cnt[0] !== n0 + 2) $display("FAIL b2b_count got %0d want %0d", dv_cnt[0], n0 + 2); else passed++;
    total++; if (prev_a !== 8'h12) $display("FAIL b2b_first got %h want 12", prev_a); else passed++;
    total++; if (last_a !== 8'h34) $display("FAIL b2b_second got %h want 34", last_a); else passed++;
    total++; if (dv_cyc[0] - edge0 !== 154) $display("FAIL b2b_second_edge got %0d want 154", dv_cyc[0] - edge0); else passed++;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin dv_cnt[i] = 0; dv_cyc[i] = 0; end
    last_a = 8'h00;
    prev_a = 8'h00;
    test_reset();
    test_8n1();
    test_parity();
    test_frame_err();
    test_break();
    test_glitch();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
